// File: rtl/bin_to_7seg_display_pkg.sv
// Shared display definitions: segment constants, the digit code table and
// the conversion FSM state type.
package bin_to_7seg_display_pkg;

  // Active-low segment patterns, bit order g..a (bit 6 = g).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Nibble -> segments; codes 10..15 are not decimal digits and stay dark.
  localparam logic [6:0] SEG_DIGIT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_7seg_display_if.sv
// Request/status bundle between the score/timing logic and the display block.
interface bin_to_7seg_display_if #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [BIN_WIDTH-1:0]    bin_value;
  logic                    lz_blank;
  logic                    blink_en;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [NUM_DIGITS*7-1:0] seg_out;

  modport master (
    output load, bin_value, lz_blank, blink_en,
    input  busy, done, overflow, seg_out
  );

  modport slave (
    input  load, bin_value, lz_blank, blink_en,
    output busy, done, overflow, seg_out
  );
endinterface

// File: rtl/bin_to_7seg_display_bcd_seg_enc.sv
// Single-digit decoder: BCD nibble to active-low seven-segment pattern.
module bcd_seg_enc
  import bin_to_7seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; non-decimal nibbles map to a dark digit via the table.
  always_comb begin
    seg = SEG_DIGIT[nibble];
  end

endmodule

// File: rtl/bin_to_7seg_display.sv
// Binary to multi-digit seven-segment display: sequential double-dabble
// conversion, leading-zero blanking, overflow dashes and blink.
module bin_to_7seg_display
  import bin_to_7seg_display_pkg::*;
#(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bin_to_7seg_display_if.slave  bus
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int DW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  state_t                  state;
  logic [BIN_WIDTH-1:0]    shift_reg, shift_step;
  logic [BW-1:0]           bcd_reg, bcd_adj, bcd_step;
  logic [BW-1:0]           disp_bcd_reg, disp_bcd_next;
  logic [CW-1:0]           cnt_reg;
  logic                    sticky_reg, sticky_step, carry;
  logic                    disp_ovf_reg, disp_ovf_next, disp_load;
  logic                    busy_reg, done_reg;
  logic [DW-1:0]           blink_cnt_reg;
  logic                    blink_phase_reg, blink_phase_next, blink_wrap;
  logic [NUM_DIGITS*7-1:0] seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   zero_above;

  // Double-dabble add-3 correction on every nibble, then shift left by one.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
  end
  assign {carry, bcd_step, shift_step} = {bcd_adj, shift_reg, 1'b0};
  assign sticky_step = sticky_reg | carry;

  // The final shift result goes straight into the display registers so the
  // new digits and the done pulse appear together in the UPDATE cycle.
  assign disp_load     = (state == SHIFT) && (cnt_reg == CW'(1));
  assign disp_bcd_next = disp_load ? bcd_step    : disp_bcd_reg;
  assign disp_ovf_next = disp_load ? sticky_step : disp_ovf_reg;

  assign blink_wrap       = (blink_cnt_reg == DW'(BLINK_DIV - 1));
  assign blink_phase_next = blink_phase_reg ^ blink_wrap;

  // Per-digit segment selection: blink, overflow dashes, leading-zero blank.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [6:0] digit_seg;

    if (gi == NUM_DIGITS - 1) begin : g_top
      assign zero_above[gi] = (disp_bcd_next[4*gi +: 4] == 4'd0);
    end else begin : g_lower
      assign zero_above[gi] = (disp_bcd_next[4*gi +: 4] == 4'd0) && zero_above[gi+1];
    end

    bcd_seg_enc u_enc (
      .nibble (disp_bcd_next[4*gi +: 4]),
      .seg    (digit_seg)
    );

    assign seg_next[7*gi +: 7] =
      (bus.blink_en && blink_phase_next)           ? SEG_BLANK :
      disp_ovf_next                                ? SEG_DASH  :
      ((gi != 0) && bus.lz_blank && zero_above[gi]) ? SEG_BLANK :
                                                     digit_seg;
  end

  // Conversion FSM with registered busy/done and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      sticky_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      disp_bcd_reg <= '0;
      disp_ovf_reg <= 1'b0;
    end else begin
      disp_bcd_reg <= disp_bcd_next;
      disp_ovf_reg <= disp_ovf_next;
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.load) begin
            shift_reg  <= bus.bin_value;
            bcd_reg    <= '0;
            sticky_reg <= 1'b0;
            cnt_reg    <= CW'(BIN_WIDTH);
            busy_reg   <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg  <= shift_step;
          bcd_reg    <= bcd_step;
          sticky_reg <= sticky_step;
          cnt_reg    <= cnt_reg - CW'(1);
          if (disp_load) begin
            done_reg <= 1'b1;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running blink divider; phase flips on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      blink_cnt_reg   <= blink_wrap ? '0 : blink_cnt_reg + DW'(1);
      blink_phase_reg <= blink_phase_next;
    end
  end

  // Registered segment outputs, dark out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= '1;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.overflow = disp_ovf_reg;
  assign bus.seg_out  = seg_reg;

endmodule

// File: doc/bin_to_7seg_display.md
Name: bin_to_7seg_display

Overview:
Parametrised multi-digit successor to the single-digit segment decoder. It converts an unsigned binary value to BCD using a sequential double-dabble engine, one bit per cycle. The result is driven to NUM_DIGITS active-low seven-segment displays, with optional leading-zero blanking, overflow indication and blink. It sits between the game's timing/score logic and the board HEX outputs.

Parameters:
BIN_WIDTH, 14, width of the binary input (14 covers 0..9999 for the default).
NUM_DIGITS, 4, number of decimal digits and displays driven.
BLINK_DIV, 25_000_000, clk cycles per blink half-period (>=2).

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous assert, active-low.
load  input  1  single-cycle request to convert bin_value; sampled only in IDLE.
bin_value  input  BIN_WIDTH  unsigned value to display; captured on an accepted load.
lz_blank  input  1  1 = blank leading zeros; digit 0 is always shown.
blink_en  input  1  1 = displayed digits toggle on/off with period 2*BLINK_DIV.
busy  output  1  high from the cycle after an accepted load until done.
done  output  1  one-cycle pulse when seg_out has been updated.
overflow  output  1  held high while the displayed value is >= 10^NUM_DIGITS.
seg_out  output  NUM_DIGITS*7  active-low segments; digit k occupies bits [7k+6:7k], bit order g..a (bit 6 = g); digit 0 is least significant.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, overflow=0, seg_out all 1s (every segment off), internal shift/BCD/display registers 0, blink counter 0, blink phase 0, FSM in IDLE.
- FSM states:
  - IDLE: load=1 captures bin_value into the shift register, clears the BCD register and overflow_sticky, sets bit counter = BIN_WIDTH, then goes to SHIFT.
  - SHIFT: one double-dabble step per cycle. Every BCD nibble >= 5 gets +3, then {bcd, shift} shifts left by 1. Any 1 shifted out of the top BCD bit sets overflow_sticky. Decrement the counter; at 0 go to UPDATE.
  - UPDATE: latch the BCD digits and overflow_sticky into the display registers, pulse done=1, return to IDLE.
- busy=1 in SHIFT and UPDATE.
- Latency: load accepted at cycle 0 -> done and new seg_out at cycle BIN_WIDTH+1 (cycle 15 for the default).
- load while busy is ignored; there is no queueing.
- The display registers hold their value between conversions. seg_out changes only in the UPDATE cycle or on a blink phase change.
- Digit encoding (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble = 1111111.
- Leading-zero blank: when lz_blank=1, digit k (k>=1) is forced to 1111111 if it and every digit above it are 0. This is evaluated combinationally on the display registers, so a lz_blank change takes effect on the next clock edge through the output register.
- Overflow: when the display overflow flag is set, every digit shows a dash (0111111), overflow=1, and lz_blank has no effect.
- Blink: a free-running counter counts 0..BLINK_DIV-1. On wrap, blink phase toggles. When blink_en=1 and phase=1, seg_out is all 1s. When blink_en=0, the counter keeps running but phase is ignored.
- seg_out is registered: one cycle from a display-register, lz_blank or blink change.
- Reset mid-conversion: everything returns to reset values, no done pulse, display blank.
- Boundaries:
  - bin_value=0: shows "0" in digit 0 (leading digits blank if lz_blank=1, else "0000").
  - bin_value = 10^N - 1 (9999): shown normally.
  - bin_value = 10^N: overflow.

Decomposition:
- Shared display package holds:
  - the segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - the digit code table;
  - the FSM state enum {IDLE, SHIFT, UPDATE}.
- Sub-module bcd_seg_enc: combinational 4-bit nibble -> 7-bit active-low segments, instantiated NUM_DIGITS times via generate.
- The double-dabble engine, blank/overflow/blink muxing and output register stay in the top module.

Test Plan:
- Reset, then load=1 with bin_value=1234, lz_blank=0, blink_en=0 -> busy for cycles 1..15, done pulse at cycle 15. seg_out digit3..0 = 1111001, 0100100, 0110000, 0011001; overflow=0.
- Load 7 with lz_blank=1 -> digit0=1111000, digits1..3=1111111. Toggle lz_blank to 0 -> digits1..3=1000000 after one cycle.
- Load 10000 -> done at cycle 15, overflow=1, all four digits 0111111. Then load 9999 -> overflow=0, all digits 0010000.
- Load 42, then pulse load with 9 at cycle 5 (busy) -> the second load is ignored, final display shows "42", exactly one done pulse.
- Deassert rst_n at cycle 8 of a 1234 conversion -> busy=0 and seg_out all 1s immediately. No done pulse. After release, a new load of 5 converts normally.
- BLINK_DIV=4, blink_en=1 with "0012" displayed -> seg_out alternates every 4 cycles between the digit pattern and all 1s. With blink_en=0 -> steady digit pattern.
